// File: rtl/inst_queue.sv
// Show-ahead circular FIFO of {instruction, pc} pairs between fetcher and decoder.
// Define INST_QUEUE_BYPASS_EN to forward a push straight to the outputs when the queue is empty.
module inst_queue #(
    parameter int DEPTH       = 16,
    parameter int PTR_BITS    = 4,
    parameter int FULL_MARGIN = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_flush_in,
    input  logic        fetcher_en_in,
    input  logic [31:0] fetcher_inst_in,
    input  logic [31:0] fetcher_pc_in,
    output logic        fetcher_full_out,
    input  logic        dispatcher_stall_in,
    output logic        decoder_inst_en_out,
    output logic [31:0] decoder_inst_out,
    output logic [31:0] decoder_pc_out
);

    localparam int CW = PTR_BITS + 1;
    localparam logic [PTR_BITS:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PTR_BITS:0] FULL_LVL = CW'(DEPTH - FULL_MARGIN);

    logic [31:0]         inst_mem [DEPTH];
    logic [31:0]         pc_mem   [DEPTH];
    logic [PTR_BITS-1:0] head;
    logic [PTR_BITS-1:0] tail;
    logic [PTR_BITS:0]   count;
    logic [PTR_BITS:0]   count_next;

    logic active;
    logic empty;
    logic bypass;
    logic pop;
    logic pop_mem;
    logic push;

    assign active = rdy_in && !rob_flush_in;
    assign empty  = (count == '0);

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = active && empty && fetcher_en_in;
`else
    assign bypass = 1'b0;
`endif

    assign decoder_inst_en_out = active && (!empty || bypass);
    assign fetcher_full_out    = (count >= FULL_LVL);

    // A bypassed entry never occupies a slot, so only a real head pop frees one.
    assign pop     = decoder_inst_en_out && !dispatcher_stall_in;
    assign pop_mem = pop && !bypass;
    assign push    = active && fetcher_en_in && !(bypass && !dispatcher_stall_in)
                     && ((count < DEPTH_C) || pop_mem);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        decoder_inst_out = 32'h0;
        decoder_pc_out   = 32'h0;
        if (bypass) begin
            decoder_inst_out = fetcher_inst_in;
            decoder_pc_out   = fetcher_pc_in;
        end else if (decoder_inst_en_out) begin
            decoder_inst_out = inst_mem[head];
            decoder_pc_out   = pc_mem[head];
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop_mem})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (rob_flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push)
                    tail <= tail + 1'b1;
                if (pop_mem)
                    head <= head + 1'b1;
                count <= count_next;
            end
        end
    end

    // NOTE: the storage arrays carry no reset; count alone decides which slots are meaningful.
    always_ff @(posedge clk_in) begin
        if (rst_in && push) begin
            inst_mem[tail] <= fetcher_inst_in;
            pc_mem[tail]   <= fetcher_pc_in;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a reference queue tracks accepted entries and
// every cycle's head/valid/full outputs are compared against it.
module tb_inst_queue;

    localparam int DEPTH       = 16;
    localparam int FULL_MARGIN = 1;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_flush_in;
    logic        fetcher_en_in;
    logic [31:0] fetcher_inst_in;
    logic [31:0] fetcher_pc_in;
    logic        fetcher_full_out;
    logic        dispatcher_stall_in;
    logic        decoder_inst_en_out;
    logic [31:0] decoder_inst_out;
    logic [31:0] decoder_pc_out;

    inst_queue #(.DEPTH(DEPTH), .PTR_BITS(4), .FULL_MARGIN(FULL_MARGIN)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .rob_flush_in        (rob_flush_in),
        .fetcher_en_in       (fetcher_en_in),
        .fetcher_inst_in     (fetcher_inst_in),
        .fetcher_pc_in       (fetcher_pc_in),
        .fetcher_full_out    (fetcher_full_out),
        .dispatcher_stall_in (dispatcher_stall_in),
        .decoder_inst_en_out (decoder_inst_en_out),
        .decoder_inst_out    (decoder_inst_out),
        .decoder_pc_out      (decoder_pc_out)
    );

    always #5 clk_in = ~clk_in;

    logic [63:0] sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          drops  = 0;
    logic        obs_en;
    logic        obs_full;
    logic [31:0] obs_inst;
    logic [31:0] obs_pc;
    logic        popped;
    logic [31:0] popped_pc;

    // One clock: drive inputs, compare outputs at the falling edge, advance the model.
    task automatic clk_step(input logic en, input logic [31:0] inst, input logic [31:0] pc,
                            input logic stall, input logic flush, input logic rdy,
                            input logic rst);
        logic        exp_en;
        logic        byp;
        logic [63:0] head_exp;
        logic [63:0] exp_data;
        logic        exp_full;
        rst_in              = rst;
        rdy_in              = rdy;
        rob_flush_in        = flush;
        fetcher_en_in       = en;
        fetcher_inst_in     = inst;
        fetcher_pc_in       = pc;
        dispatcher_stall_in = stall;
        popped              = 1'b0;
        popped_pc           = 32'h0;
        @(negedge clk_in);
        obs_en   = decoder_inst_en_out;
        obs_full = fetcher_full_out;
        obs_inst = decoder_inst_out;
        obs_pc   = decoder_pc_out;
        if (!rst) begin
            sb.delete();
        end else begin
            byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
            byp = rdy && !flush && en && (sb.size() == 0);
`endif
            exp_en   = rdy && !flush && ((sb.size() != 0) || byp);
            head_exp = byp ? {inst, pc} : ((sb.size() != 0) ? sb[0] : 64'h0);
            exp_data = exp_en ? head_exp : 64'h0;
            exp_full = (sb.size() >= DEPTH - FULL_MARGIN);
            n_cmp++;
            if (obs_en !== exp_en) begin
                n_fail++;
                $display("FAIL head_valid: got %0b expected %0b", obs_en, exp_en);
            end
            n_cmp++;
            if ({obs_inst, obs_pc} !== exp_data) begin
                n_fail++;
                $display("FAIL head_data: got inst=%h pc=%h expected inst=%h pc=%h",
                         obs_inst, obs_pc, exp_data[63:32], exp_data[31:0]);
            end
            n_cmp++;
            if (obs_full !== exp_full) begin
                n_fail++;
                $display("FAIL full: got %0b expected %0b", obs_full, exp_full);
            end
            if (rdy) begin
                if (flush) begin
                    sb.delete();
                end else begin
                    if (exp_en && !stall) begin
                        popped    = 1'b1;
                        popped_pc = obs_pc;
                    end
                    if (byp) begin
                        if (stall)
                            sb.push_back({inst, pc});
                    end else begin
                        if (exp_en && !stall)
                            void'(sb.pop_front());
                        if (en) begin
                            if (sb.size() < DEPTH)
                                sb.push_back({inst, pc});
                            else
                                drops++;
                        end
                    end
                end
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic drain(output int n_pop, output logic [31:0] last_pc);
        int guard = 0;
        n_pop   = 0;
        last_pc = 32'h0;
        while (sb.size() != 0 && guard < 100) begin
            clk_step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
            if (popped) begin
                n_pop++;
                last_pc = popped_pc;
            end
            guard++;
        end
        n_cmp++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", sb.size());
        end
        clk_step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (obs_en !== 1'b0) begin
            n_fail++;
            $display("FAIL drained_empty: got en=%0b expected 0", obs_en);
        end
    endtask

    task automatic test_reset();
        clk_step(1'b1, 32'hDEAD0001, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0);
        clk_step(1'b1, 32'hDEAD0002, 32'h104, 1'b1, 1'b0, 1'b1, 1'b0);
        clk_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({obs_en, obs_full, obs_inst, obs_pc} !== 66'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%0b full=%0b inst=%h pc=%h expected all 0",
                     obs_en, obs_full, obs_inst, obs_pc);
        end
    endtask

    task automatic test_fill();
        int          n_pop;
        logic [31:0] last_pc;
        drops = 0;
        for (int i = 0; i < 15; i++)
            clk_step(1'b1, 32'h1000 + 32'(i), 32'(i * 4), 1'b1, 1'b0, 1'b1, 1'b1);
        clk_step(1'b1, 32'h1000 + 32'd15, 32'd60, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (obs_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_after_15: got %0b expected 1", obs_full);
        end
        clk_step(1'b1, 32'h00000013, 32'd64, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (obs_pc !== 32'h0 || obs_inst !== 32'h1000) begin
            n_fail++;
            $display("FAIL head_at_16: got inst=%h pc=%h expected inst=00001000 pc=0", obs_inst, obs_pc);
        end
        clk_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (drops !== 1) begin
            n_fail++;
            $display("FAIL dropped_pushes: got %0d expected 1", drops);
        end
        drain(n_pop, last_pc);
        n_cmp++;
        if (n_pop !== 16 || last_pc !== 32'd60) begin
            n_fail++;
            $display("FAIL fill_drain: got %0d pops last pc %h expected 16 pops last pc 3c", n_pop, last_pc);
        end
    endtask

    task automatic test_wrap();
        int          pushed  = 0;
        int          cyc     = 0;
        logic [31:0] next_pc = 32'h0;
        logic        do_push;
        while ((pushed < 40 || sb.size() != 0) && cyc < 400) begin
            do_push = (pushed < 40) && (sb.size() < DEPTH - FULL_MARGIN);
            clk_step(do_push, 32'hA000 + 32'(pushed), 32'(pushed * 4), cyc[0], 1'b0, 1'b1, 1'b1);
            if (do_push)
                pushed++;
            if (popped) begin
                n_cmp++;
                if (popped_pc !== next_pc) begin
                    n_fail++;
                    $display("FAIL wrap_order: got pc %h expected %h", popped_pc, next_pc);
                end
                next_pc += 32'd4;
            end
            cyc++;
        end
        n_cmp++;
        if (next_pc !== 32'hA0) begin
            n_fail++;
            $display("FAIL wrap_count: got next pc %h expected a0", next_pc);
        end
    endtask

    task automatic test_full_push_pop();
        int          n_pop;
        logic [31:0] last_pc;
        for (int i = 0; i < 16; i++)
            clk_step(1'b1, 32'h2000 + 32'(i), 32'h400 + 32'(i * 4), 1'b1, 1'b0, 1'b1, 1'b1);
        clk_step(1'b1, 32'h5000, 32'h5000, 1'b0, 1'b0, 1'b1, 1'b1);
        clk_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (obs_pc !== 32'h404 || obs_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_swap_head: got pc=%h full=%0b expected pc=404 full=1", obs_pc, obs_full);
        end
        drain(n_pop, last_pc);
        n_cmp++;
        if (n_pop !== 16 || last_pc !== 32'h5000) begin
            n_fail++;
            $display("FAIL full_swap_drain: got %0d pops last pc %h expected 16 pops last pc 5000", n_pop, last_pc);
        end
    endtask

    task automatic test_flush();
        int          n_pop;
        logic [31:0] last_pc;
        for (int i = 0; i < 5; i++)
            clk_step(1'b1, 32'h3000 + 32'(i), 32'h600 + 32'(i * 4), 1'b1, 1'b0, 1'b1, 1'b1);
        clk_step(1'b1, 32'h7000, 32'h7000, 1'b0, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (obs_en !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle_en: got %0b expected 0", obs_en);
        end
        clk_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (obs_en !== 1'b0 || obs_full !== 1'b0) begin
            n_fail++;
            $display("FAIL after_flush: got en=%0b full=%0b expected 0 0", obs_en, obs_full);
        end
        clk_step(1'b1, 32'h8000, 32'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
`ifdef INST_QUEUE_BYPASS_EN
        if (obs_en !== 1'b1) begin
            n_fail++;
            $display("FAIL push_latency_n0: got en=%0b expected 1", obs_en);
        end
`else
        if (obs_en !== 1'b0) begin
            n_fail++;
            $display("FAIL push_latency_n0: got en=%0b expected 0", obs_en);
        end
`endif
        clk_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (obs_en !== 1'b1 || obs_pc !== 32'h8000) begin
            n_fail++;
            $display("FAIL push_latency_n1: got en=%0b pc=%h expected 1 8000", obs_en, obs_pc);
        end
        drain(n_pop, last_pc);
        n_cmp++;
        if (n_pop !== 1) begin
            n_fail++;
            $display("FAIL flush_drain: got %0d pops expected 1", n_pop);
        end
    endtask

    task automatic test_rdy_hold();
        int          n_pop;
        logic [31:0] last_pc;
        for (int i = 0; i < 14; i++)
            clk_step(1'b1, 32'h4000 + 32'(i), 32'h800 + 32'(i * 4), 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            clk_step(1'b1, 32'h9000 + 32'(i), 32'h9000, 1'b0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (obs_en !== 1'b0 || obs_full !== 1'b0) begin
                n_fail++;
                $display("FAIL rdy_low: got en=%0b full=%0b expected 0 0", obs_en, obs_full);
            end
        end
        clk_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (obs_pc !== 32'h800 || obs_full !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_resume: got pc=%h full=%0b expected 800 0", obs_pc, obs_full);
        end
        drain(n_pop, last_pc);
        n_cmp++;
        if (n_pop !== 14 || last_pc !== 32'h834) begin
            n_fail++;
            $display("FAIL rdy_drain: got %0d pops last pc %h expected 14 pops last pc 834", n_pop, last_pc);
        end
    endtask

    task automatic test_back_to_back();
        int          n_pop = 0;
        int          d_pop;
        logic [31:0] last_pc;
        for (int i = 0; i < 8; i++) begin
            clk_step(1'b1, 32'hB000 + 32'(i), 32'hC00 + 32'(i * 4), 1'b0, 1'b0, 1'b1, 1'b1);
            if (popped)
                n_pop++;
        end
        drain(d_pop, last_pc);
        n_cmp++;
        if (n_pop + d_pop !== 8 || last_pc !== 32'hC1C) begin
            n_fail++;
            $display("FAIL back_to_back: got %0d pops last pc %h expected 8 pops last pc c1c",
                     n_pop + d_pop, last_pc);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_full_push_pop();
        test_flush();
        test_rdy_hold();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
